ram_arbiter: RTL and testbench

- Shares one synchronous byte-enabled RAM port between two requesters: m0 = instruction fetch, m1 = data load/store.
- Round-robin arbitration; one request accepted per cycle, fully pipelined.
- Routes the 1-cycle-latency read data back to the requester that issued it.
- Sits between the core's fetch/LSU and one port of the on-chip RAM.

---
 rtl/ram_arbiter.sv | 109 ++++++++++
 tb/tb_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one byte-enabled synchronous RAM port
// between instruction fetch (m0) and data load/store (m1).
module ram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_req_valid,
  output logic                    m0_req_ready,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic                    m0_rsp_valid,
  output logic [DATA_WIDTH-1:0]   m0_rsp_rdata,
  input  logic                    m1_req_valid,
  output logic                    m1_req_ready,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic                    m1_rsp_valid,
  output logic [DATA_WIDTH-1:0]   m1_rsp_rdata,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_di,
  input  logic [DATA_WIDTH-1:0]   ram_do
);

  localparam int STRB = DATA_WIDTH / 8;

  logic pend_valid;
  logic pend_owner;
  logic pend_write;
  logic last_grant;

  logic gnt0;
  logic gnt1;
  logic gnt_write;

  // Ties go to whoever was not granted last; reset forces no grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        m0_req_valid & m1_req_valid: begin
          gnt0 = last_grant;
          gnt1 = ~last_grant;
        end
        m0_req_valid & ~m1_req_valid: gnt0 = 1'b1;
        m1_req_valid & ~m0_req_valid: gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign m0_req_ready = gnt0;
  assign m1_req_ready = gnt1;

  always_comb begin
    ram_we   = '0;
    ram_addr = '0;
    ram_di   = '0;
    unique case (1'b1)
      gnt0: begin
        ram_we   = m0_wstrb;
        ram_addr = m0_addr;
        ram_di   = m0_wdata;
      end
      gnt1: begin
        ram_we   = m1_wstrb;
        ram_addr = m1_addr;
        ram_di   = m1_wdata;
      end
      default: ;
    endcase
  end

  assign gnt_write = (gnt0 & (m0_wstrb != '0))
                   | (gnt1 & (m1_wstrb != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_owner <= 1'b0;
      pend_write <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      pend_valid <= gnt0 | gnt1;
      pend_owner <= gnt1;
      pend_write <= gnt_write;
      if (gnt0 | gnt1)
        last_grant <= gnt1;
    end
  end

  // The RAM holds its output on writes, so write responses carry zero.
  assign m0_rsp_valid = pend_valid & ~pend_owner;
  assign m1_rsp_valid = pend_valid & pend_owner;

  assign m0_rsp_rdata = (m0_rsp_valid & ~pend_write)
                      ? ram_do : '0;
  assign m1_rsp_rdata = (m1_rsp_valid & ~pend_write)
                      ? ram_do : '0;

  logic unused_strb;
  assign unused_strb = (STRB == 0);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, reference model checked every
// cycle, directed scenarios with literal expectations, random traffic.
module tb_ram_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req_valid, m1_req_valid;
  logic          m0_req_ready, m1_req_ready;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [SW-1:0] m0_wstrb, m1_wstrb;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_rsp_valid, m1_rsp_valid;
  logic [DW-1:0] m0_rsp_rdata, m1_rsp_rdata;
  logic [SW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_req_valid (m0_req_valid),
    .m0_req_ready (m0_req_ready),
    .m0_addr      (m0_addr),
    .m0_wstrb     (m0_wstrb),
    .m0_wdata     (m0_wdata),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_rdata (m0_rsp_rdata),
    .m1_req_valid (m1_req_valid),
    .m1_req_ready (m1_req_ready),
    .m1_addr      (m1_addr),
    .m1_wstrb     (m1_wstrb),
    .m1_wdata     (m1_wdata),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_rdata (m1_rsp_rdata),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_di       (ram_di),
    .ram_do       (ram_do)
  );

  function automatic logic [DW-1:0] init_word(int i);
    case (i)
      'h010:   return 32'hDEADBEEF;
      'h001:   return 32'hA5A50001;
      'h002:   return 32'h5A5A0002;
      'h020:   return 32'h11223344;
      default: return (32'(i) * 32'h01010101) ^ 32'h3C5A0000;
    endcase
  endfunction

  // Synchronous RAM: output holds on write cycles.
  logic [DW-1:0] ram_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = init_word(i);
    ram_do = '0;
    forever begin
      @(posedge clk);
      if (ram_we != '0) begin
        for (int b = 0; b < SW; b++)
          if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] = ram_di[b*8 +: 8];
      end else begin
        ram_do = ram_mem[ram_addr];
      end
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  int            last;
  bit            pend_v;
  int            pend_o;
  bit            pend_w;
  logic [DW-1:0] pend_d;
  logic          s_r0, s_r1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend_v = 0;
    last   = 1;
  endtask

  task automatic check_step();
    int            g;
    logic [SW-1:0] e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_di;
    logic [DW-1:0] e_d0, e_d1;
    bit            e_v0, e_v1;
    g = -1;
    if (!reset) begin
      if (m0_req_valid && m1_req_valid) g = (last == 0) ? 1 : 0;
      else if (m0_req_valid) g = 0;
      else if (m1_req_valid) g = 1;
    end
    e_we = '0; e_addr = '0; e_di = '0;
    if (g == 0) begin e_we = m0_wstrb; e_addr = m0_addr; e_di = m0_wdata; end
    if (g == 1) begin e_we = m1_wstrb; e_addr = m1_addr; e_di = m1_wdata; end
    e_v0 = pend_v && pend_o == 0;
    e_v1 = pend_v && pend_o == 1;
    e_d0 = (e_v0 && !pend_w) ? pend_d : '0;
    e_d1 = (e_v1 && !pend_w) ? pend_d : '0;
    s_r0 = m0_req_ready;
    s_r1 = m1_req_ready;
    chk("m0_req_ready", 64'(m0_req_ready), 64'(g == 0));
    chk("m1_req_ready", 64'(m1_req_ready), 64'(g == 1));
    chk("ram_we",   64'(ram_we),   64'(e_we));
    chk("ram_addr", 64'(ram_addr), 64'(e_addr));
    chk("ram_di",   64'(ram_di),   64'(e_di));
    chk("m0_rsp_valid", 64'(m0_rsp_valid), 64'(e_v0));
    chk("m1_rsp_valid", 64'(m1_rsp_valid), 64'(e_v1));
    chk("m0_rsp_rdata", 64'(m0_rsp_rdata), 64'(e_d0));
    chk("m1_rsp_rdata", 64'(m1_rsp_rdata), 64'(e_d1));
    if (g >= 0) begin
      pend_v = 1;
      pend_o = g;
      pend_w = (e_we != '0);
      pend_d = pend_w ? '0 : ref_mem[e_addr];
      for (int b = 0; b < SW; b++)
        if (e_we[b]) ref_mem[e_addr][b*8 +: 8] = e_di[b*8 +: 8];
      last = g;
    end else begin
      pend_v = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int m, logic v, logic [AW-1:0] a,
                       logic [SW-1:0] s, logic [DW-1:0] d);
    if (m == 0) begin
      m0_req_valid = v; m0_addr = a; m0_wstrb = s; m0_wdata = d;
    end else begin
      m1_req_valid = v; m1_addr = a; m1_wstrb = s; m1_wdata = d;
    end
  endtask

  initial begin
    int nready, nrsp, first_m1;
    reset = 1'b1;
    drive(0, 0, '0, '0, '0);
    drive(1, 0, '0, '0, '0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    model_reset();
    s_r0 = 0; s_r1 = 0;

    // Reset state with both requesters asking
    cycle();
    drive(0, 1, 10'h001, '0, '0);
    drive(1, 1, 10'h002, '0, '0);
    cycle();
    chk("reset_ready0", 64'(s_r0), 64'd0);
    chk("reset_ready1", 64'(s_r1), 64'd0);
    chk("reset_rsp0", 64'(m0_rsp_valid), 64'd0);
    reset = 1'b0;
    drive(0, 0, '0, '0, '0);
    drive(1, 0, '0, '0, '0);
    cycle();

    // m0 alone reads 0x010
    drive(0, 1, 10'h010, '0, '0);
    cycle();
    drive(0, 0, '0, '0, '0);
    chk("t1_ready0", 64'(s_r0), 64'd1);
    chk("t1_rsp0_valid", 64'(m0_rsp_valid), 64'd1);
    chk("t1_rsp0_data", 64'(m0_rsp_rdata), 64'hDEADBEEF);
    chk("t1_rsp1_valid", 64'(m1_rsp_valid), 64'd0);

    // m1 alone first so the following tie starts with m0
    drive(1, 1, 10'h002, '0, '0);
    cycle();
    drive(0, 1, 10'h001, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_grant0", 64'(s_r0), 64'(i % 2 == 0));
      if (i % 2 == 0) begin
        chk("t2_rsp0_valid", 64'(m0_rsp_valid), 64'd1);
        chk("t2_rsp0_data", 64'(m0_rsp_rdata), 64'hA5A50001);
      end else begin
        chk("t2_rsp1_valid", 64'(m1_rsp_valid), 64'd1);
        chk("t2_rsp1_data", 64'(m1_rsp_rdata), 64'h5A5A0002);
      end
    end
    drive(0, 0, '0, '0, '0);

    // Partial write then readback
    drive(1, 1, 10'h020, 4'b0100, 32'h00AB0000);
    cycle();
    chk("t3_wr_rsp_valid", 64'(m1_rsp_valid), 64'd1);
    chk("t3_wr_rsp_data", 64'(m1_rsp_rdata), 64'd0);
    drive(1, 1, 10'h020, '0, '0);
    cycle();
    drive(1, 0, '0, '0, '0);
    chk("t3_rd_data", 64'(m1_rsp_rdata), 64'h11AB3344);

    // m0 streams 8 reads alone
    nready = 0; nrsp = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, AW'(10'h030 + i), '0, '0);
      cycle();
      if (s_r0) nready++;
      if (m0_rsp_valid) nrsp++;
    end
    drive(0, 0, '0, '0, '0);
    chk("t4_ready_count", 64'(nready), 64'd8);
    chk("t4_rsp_count", 64'(nrsp), 64'd8);

    // Reset mid-cycle drops in-flight response
    drive(0, 1, 10'h010, '0, '0);
    cycle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t5_rsp_dropped", 64'(m0_rsp_valid), 64'd0);
    drive(1, 1, 10'h002, '0, '0);
    cycle();
    chk("t5_ready0_rst", 64'(s_r0), 64'd0);
    chk("t5_ready1_rst", 64'(s_r1), 64'd0);
    chk("t5_no_rsp", 64'(m0_rsp_valid | m1_rsp_valid), 64'd0);
    reset = 1'b0;
    drive(0, 1, 10'h001, '0, '0);
    cycle();
    chk("t5_tie_m0", 64'(s_r0), 64'd1);
    chk("t5_tie_not_m1", 64'(s_r1), 64'd0);
    drive(0, 0, '0, '0, '0);
    drive(1, 0, '0, '0, '0);

    // m1 waiting while m0 holds valid
    drive(1, 1, 10'h005, '0, '0);
    cycle();
    drive(0, 1, 10'h007, '0, '0);
    drive(1, 1, 10'h009, '0, '0);
    first_m1 = -1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_r1 && first_m1 < 0) begin
        first_m1 = i;
        drive(1, 0, '0, '0, '0);
      end
    end
    chk("t6_m1_wait", 64'(first_m1), 64'd1);
    drive(0, 0, '0, '0, '0);
    drive(1, 0, '0, '0, '0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if (!(m0_req_valid && !s_r0 && $urandom_range(0, 3) != 0))
        drive(0, $urandom_range(0, 9) < 7, AW'($urandom_range(0, 63)),
              ($urandom_range(0, 2) == 0) ? SW'($urandom_range(1, 15)) : '0,
              $urandom);
      if (!(m1_req_valid && !s_r1 && $urandom_range(0, 3) != 0))
        drive(1, $urandom_range(0, 9) < 7, AW'($urandom_range(0, 63)),
              ($urandom_range(0, 2) == 0) ? SW'($urandom_range(1, 15)) : '0,
              $urandom);
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        model_reset();
        cycle();
        reset = 1'b0;
      end else begin
        cycle();
      end
    end
    drive(0, 0, '0, '0, '0);
    drive(1, 0, '0, '0, '0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
